// File: rtl/pmu_pkg.sv
// Shared PMU configuration-path definitions.
// Provides the default field widths and FIFO depth used by both the
// bitstream deserializer and the PMU address generator, plus the packed
// word layout {data, addr} and a helper that builds it from raw bits.
package pmu_pkg;

  localparam int PMU_DATA_WIDTH = 32;
  localparam int PMU_ADDR_WIDTH = 8;
  localparam int PMU_FIFO_WIDTH = PMU_DATA_WIDTH + PMU_ADDR_WIDTH;
  localparam int PMU_WORD_DEPTH = 4;

  // Data occupies the upper bits, address the lower bits.
  typedef struct packed {
    logic [PMU_DATA_WIDTH-1:0] data;
    logic [PMU_ADDR_WIDTH-1:0] addr;
  } pmu_word_t;

  function automatic pmu_word_t pmu_split(input logic [PMU_FIFO_WIDTH-1:0] w);
    return pmu_word_t'(w);
  endfunction

endpackage

// File: rtl/pmu_sync_fifo.sv
// Single-clock FIFO for assembled PMU configuration words.
// Ports:
//   clk_i, rst_ni  clock / synchronous active-low reset
//   flush_i        drops all entries; push and pop are ignored that cycle
//   push_i/data_i  write side (caller guarantees no push when full
//                  unless popping in the same cycle)
//   pop_i          read side (ignored when empty)
//   data_o         head entry, forced to 0 when empty
//   valid_o        non-empty
//   level_o        occupancy 0..DEPTH
module pmu_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign valid_o = (r_level != '0);
  assign w_push  = push_i & ~flush_i;
  assign w_pop   = pop_i & valid_o & ~flush_i;
  assign data_o  = valid_o ? r_mem[r_rd_ptr] : '0;
  assign level_o = r_level;

  // Storage is not reset; data_o masks it while empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      // Simultaneous push and pop leave the level unchanged.
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

endmodule

// File: rtl/bitstream_deserializer.sv
// Serial-to-parallel front end of the PMU configuration path.
// Collects one bit per cycle MSB first into FIFO_WIDTH-bit {data, addr}
// words and queues them for the address generator.
// Ports:
//   clk_i, rst_ni          clock / synchronous active-low reset
//   flush_i                discard partial word and all queued words
//   bit_i, bit_valid_i     serial input, bit_ready_o accepts it
//   word_o, word_valid_o   head word (0 when empty) / non-empty
//   word_ready_i           downstream consumes head word
//   level_o                queued word count
module bitstream_deserializer
  import pmu_pkg::*;
#(
  parameter int DATA_WIDTH = PMU_DATA_WIDTH,
  parameter int ADDR_WIDTH = PMU_ADDR_WIDTH,
  parameter int FIFO_WIDTH = DATA_WIDTH + ADDR_WIDTH,
  parameter int DEPTH      = PMU_WORD_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     bit_i,
  input  logic                     bit_valid_i,
  output logic                     bit_ready_o,
  output logic [FIFO_WIDTH-1:0]    word_o,
  output logic                     word_valid_o,
  input  logic                     word_ready_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int CW = $clog2(FIFO_WIDTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [FIFO_WIDTH-2:0] r_sr;
  logic [CW-1:0]         r_cnt;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_push;

  assign w_last = (r_cnt == CW'(FIFO_WIDTH - 1));
  assign w_pop  = word_valid_o & word_ready_i;

  // Only the word-completing bit can stall, and only when the FIFO is full
  // and not draining this cycle. The pop term makes this combinational
  // from word_ready_i so a full FIFO still sustains one word per word time.
  assign bit_ready_o = rst_ni & ~flush_i &
                       (~w_last | (level_o != LW'(DEPTH)) | w_pop);

  assign w_accept = bit_valid_i & bit_ready_o;
  assign w_push   = w_accept & w_last;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_sr  <= {r_sr[FIFO_WIDTH-3:0], bit_i};
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  pmu_sync_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  ({r_sr, bit_i}),
    .pop_i   (w_pop),
    .data_o  (word_o),
    .valid_o (word_valid_o),
    .level_o (level_o)
  );

endmodule
